// File: rtl/slow_clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slow_clock_pkg
// Purpose  : Shared state type and default rate constants for the slow-clock
//            divider and period meter.
// Revision : 1.0  initial release
// ============================================================================
package slow_clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } meter_state_t;

    localparam int unsigned c_timeout_default       = 50_000_000;
    localparam int unsigned c_expect_period_default = 5_000_002;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Two-flop synchronizer plus history flop; flags rising and
//            falling edges of an asynchronous input (KEY, SW, slow clocks).
// Revision : 1.0  initial release
// ============================================================================
module sync_edge_detect (
    input  logic Clock,
    input  logic reset,
    input  logic clear,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else if (clear) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign rise =  r_sync2 & ~r_hist;
    assign fall = ~r_sync2 &  r_hist;

endmodule
`default_nettype wire

// File: rtl/slow_clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : slow_clock_period_meter
// Purpose  : Measures period and high time of a slow asynchronous input in
//            Clock cycles; flags input loss. Optional tolerance check is
//            enabled by defining PERIOD_METER_TOL_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module slow_clock_period_meter
    import slow_clock_pkg::*;
#(
    parameter int          CNT_W         = 32,
    parameter int unsigned TIMEOUT       = c_timeout_default,
    parameter int unsigned EXPECT_PERIOD = c_expect_period_default,
    parameter int unsigned TOL           = 1000
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout,
    output logic             in_tol
);

    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_lost = CNT_W'(TIMEOUT - 1);

    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_active;
    logic             w_publish;
    logic             w_lost;

    meter_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cap;
    logic             r_fall_seen;

    sync_edge_detect u_sync (
        .Clock  (Clock),
        .reset  (reset),
        .clear  (clear),
        .sig_in (sig_in),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_active  = (r_state != IDLE);
    assign w_publish = w_active & w_rise;
    // A rise on the timeout cycle still publishes.
    assign w_lost    = w_active & ~w_rise & (r_cnt == c_cnt_lost);

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hi_cap    <= '0;
            r_fall_seen <= 1'b0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hi_cap    <= '0;
            r_fall_seen <= 1'b0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_rise) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= w_cnt_inc;
            end

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state     <= ARMED;
                        r_fall_seen <= 1'b0;
                    end
                end
                ARMED, RUN: begin
                    if (w_publish) begin
                        period      <= w_cnt_inc;
                        high_time   <= r_fall_seen ? r_hi_cap : w_cnt_inc;
                        valid       <= 1'b1;
                        locked      <= 1'b1;
                        timeout     <= 1'b0;
                        r_fall_seen <= 1'b0;
                        r_state     <= RUN;
                    end else begin
                        if (w_fall) begin
                            r_hi_cap    <= w_cnt_inc;
                            r_fall_seen <= 1'b1;
                        end
                        if (w_lost) begin
                            r_state <= IDLE;
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PERIOD_METER_TOL_CHECK_EN
    // One extra bit keeps the bound arithmetic free of wrap-around.
    localparam logic [CNT_W:0] c_exp = (CNT_W+1)'(EXPECT_PERIOD);
    localparam logic [CNT_W:0] c_tol = (CNT_W+1)'(TOL);

    logic [CNT_W:0] w_meas;
    logic           w_in_range;

    assign w_meas     = {1'b0, w_cnt_inc};
    assign w_in_range = ((w_meas + c_tol) >= c_exp) && (w_meas <= (c_exp + c_tol));

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            in_tol <= 1'b0;
        end else if (clear) begin
            in_tol <= 1'b0;
        end else if (w_publish) begin
            in_tol <= w_in_range;
        end else if (w_lost) begin
            in_tol <= 1'b0;
        end
    end
`else
    logic w_tol_cfg_unused;
    assign w_tol_cfg_unused = |{EXPECT_PERIOD, TOL};
    assign in_tol           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slow_clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_slow_clock_period_meter
// Purpose  : Directed bench for slow_clock_period_meter with an edge-time
//            reference model and literal spot checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_slow_clock_period_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 100;
    localparam int EXP   = 20;
    localparam int TL    = 2;
    localparam int NCYC  = 8192;
`ifdef PERIOD_METER_TOL_CHECK_EN
    localparam bit c_tol_on = 1'b1;
`else
    localparam bit c_tol_on = 1'b0;
`endif

    logic             Clock  = 1'b0;
    logic             reset  = 1'b0;
    logic             sig_in = 1'b0;
    logic             clear  = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;
    logic             in_tol;

    always #5 Clock = ~Clock;

    slow_clock_period_meter #(
        .CNT_W         (CNT_W),
        .TIMEOUT       (TO),
        .EXPECT_PERIOD (EXP),
        .TOL           (TL)
    ) dut (
        .Clock     (Clock),
        .reset     (reset),
        .sig_in    (sig_in),
        .clear     (clear),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout),
        .in_tol    (in_tol)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: works on edge times (cycle indices) of the sampled input.
    bit samp [NCYC];
    int n      = 0;
    int lc     = -1;
    int ref_c  = -1;
    int fall_c = -1;
    int m_period = 0;
    int m_high   = 0;
    bit m_valid = 0, m_locked = 0, m_timeout = 0, m_intol = 0;

    function automatic bit eff(input int j);
        return (j >= 0 && j > lc && j < NCYC) ? samp[j] : 1'b0;
    endfunction

    always @(posedge Clock) begin : model
        bit r;
        bit f;
        int p;
        if (n < NCYC) samp[n] = sig_in;
        r = eff(n-2) & ~eff(n-3);
        f = ~eff(n-2) & eff(n-3);
        m_valid = 1'b0;
        if (!reset || clear) begin
            m_period = 0; m_high = 0; m_locked = 0; m_timeout = 0; m_intol = 0;
            ref_c = -1; fall_c = -1; lc = n;
        end else if (r) begin
            if (ref_c >= 0) begin
                p         = n - ref_c;
                m_period  = p;
                m_high    = (fall_c > ref_c) ? fall_c - ref_c : p;
                m_valid   = 1'b1;
                m_locked  = 1'b1;
                m_timeout = 1'b0;
                m_intol   = c_tol_on && (p >= EXP - TL) && (p <= EXP + TL);
            end
            ref_c = n;
        end else if (ref_c >= 0) begin
            if (f) fall_c = n;
            if (n - ref_c == TO) begin
                m_timeout = 1'b1; m_locked = 1'b0; m_intol = 1'b0; ref_c = -1;
            end
        end
        n++;
    end

    always @(posedge Clock) begin : compare
        #1;
        check("period",    period,    m_period);
        check("high_time", high_time, m_high);
        check("valid",     valid,     m_valid);
        check("locked",    locked,    m_locked);
        check("timeout",   timeout,   m_timeout);
        check("in_tol",    in_tol,    m_intol);
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge Clock);
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        repeat (reps) begin
            sig_in = 1'b1; cyc(hi);
            sig_in = 1'b0; cyc(lo);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        cyc(4);
        check("rst_period", period, 0);
        check("rst_locked", locked, 0);
        check("rst_valid",  valid,  0);
        reset = 1'b1;
        cyc(3);

        wave(10, 10, 6);
        check("steady_period", period,    20);
        check("steady_high",   high_time, 10);
        check("steady_locked", locked,    1);
        check("steady_in_tol", in_tol,    c_tol_on);

        // Reset in the middle of a count while running.
        sig_in = 1'b1; cyc(10);
        sig_in = 1'b0; cyc(4);
        reset = 1'b0;
        #1;
        check("midrst_period", period,    0);
        check("midrst_high",   high_time, 0);
        check("midrst_locked", locked,    0);
        cyc(3);
        reset = 1'b1;
        cyc(5);
        sig_in = 1'b1; cyc(10);
        sig_in = 1'b0; cyc(10);
        check("first_rise_period", period, 0);
        check("first_rise_locked", locked, 0);

        wave(10, 10, 4);
        check("relock_period", period, 20);

        wave(12, 11, 3);
        check("drift23_period", period,    23);
        check("drift23_high",   high_time, 12);
        check("drift23_in_tol", in_tol,    0);
        wave(9, 9, 3);
        check("drift18_period", period,    18);
        check("drift18_in_tol", in_tol,    c_tol_on);

        wave(1, 1, 4);
        check("min_period", period,    2);
        check("min_high",   high_time, 1);

        // Rise lands on the timeout cycle.
        wave(50, 50, 3);
        check("edge_to_period",  period,  100);
        check("edge_to_timeout", timeout, 0);
        check("edge_to_locked",  locked,  1);

        cyc(120);
        check("loss_timeout", timeout,   1);
        check("loss_locked",  locked,    0);
        check("loss_period",  period,    100);
        check("loss_high",    high_time, 50);

        sig_in = 1'b1; cyc(10);
        sig_in = 1'b0; cyc(10);
        check("recov1_timeout", timeout, 1);
        wave(10, 10, 2);
        check("recov2_timeout", timeout, 0);
        check("recov2_locked",  locked,  1);
        check("recov2_period",  period,  20);

        // Clear asserted on the cycle the rise is detected.
        sig_in = 1'b1; cyc(3);
        clear = 1'b1;  cyc(1);
        clear = 1'b0;
        check("clr_valid",  valid,  0);
        check("clr_period", period, 0);
        check("clr_locked", locked, 0);
        cyc(6);
        sig_in = 1'b0; cyc(10);

        wave(30, 10, 2);
        check("stuck_period", period,    40);
        check("stuck_high",   high_time, 30);
        cyc(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slow_clock_period_meter.md
# slow_clock_period_meter

Measures the period and high time of a slow, asynchronous square wave, such as the board's divided one-hertz tick or a user clock, by counting `Clock` cycles between its edges. Publishes each result with a one-cycle valid strobe. Flags loss of the input through a timeout. It is the checking end of the slow-clock generators: it sits beside a divider and confirms on-chip that the divider's output rate is what was intended.

## Interface
Parameters:
- `CNT_W`, 32, width of the cycle counter and of both result outputs.
- `TIMEOUT`, 50000000, number of cycles without a rising edge before the input is declared lost. Must be less than 2^`CNT_W`.
- `EXPECT_PERIOD`, 5000002, nominal period in cycles. Used only when `PERIOD_METER_TOL_CHECK_EN` is defined.
- `TOL`, 1000, allowed ± deviation from `EXPECT_PERIOD` in cycles. Used only when `PERIOD_METER_TOL_CHECK_EN` is defined.

Ports:
- `Clock`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `sig_in`, in, 1: slow input, asynchronous to `Clock`.
- `clear`, in, 1: synchronous soft clear, active-high.
- `period`, out, `CNT_W`: last measured rising-to-rising period in cycles.
- `high_time`, out, `CNT_W`: high time belonging to that period, rising-to-falling, in cycles.
- `valid`, out, 1: one-cycle strobe when `period` and `high_time` update.
- `locked`, out, 1: at least one period measured and no timeout since.
- `timeout`, out, 1: sticky; input lost.
- `in_tol`, out, 1: last `period` is within `EXPECT_PERIOD` ± `TOL`.

## Operation
- **Synchronizer:** `sig_in` passes through a two-flop synchronizer, then a history flop.
- **Edge detection:**
  - Rising edge (`rise`): synchronized = 1 and history = 0.
  - Falling edge (`fall`): synchronized = 0 and history = 1.
- **Counter:** `cnt` is cleared to 0 on the `rise` cycle and increments by 1 on every other cycle. It saturates at `TIMEOUT`.
  - On a `rise`, the measured period is `cnt`+1, i.e. the cycle distance between the two `rise` cycles.
  - On a `fall`, `hi_cap` <= `cnt`+1 is captured internally.
- **State machine:**
  - **IDLE:** no reference edge yet. On `rise`, clear `cnt` and go to ARMED. `fall` is ignored.
  - **ARMED:** counting the first period. On `rise`, publish results and go to RUN. When `cnt` reaches `TIMEOUT`-1, go to IDLE and set `timeout`.
  - **RUN:** same as ARMED. Every `rise` publishes results. On timeout, go to IDLE, set `timeout` and drop `locked`.
- **Publishing** happens on the `rise` cycle while in ARMED or RUN:
  - `period` <= `cnt`+1
  - `high_time` <= `hi_cap` if a `fall` was seen since the previous `rise`, else `cnt`+1 (the input never went low)
  - `valid` <= 1 for that one cycle
  - `timeout` <= 0
  - `locked` <= 1
- **Outputs** are held between publications. A timeout does not clear `period` or `high_time`.
- **Boundary rules:**
  - `clear` and `rise` in the same cycle: `clear` wins, giving IDLE with all outputs at reset values.
  - `rise` and timeout in the same cycle: `rise` wins and the result is published.
  - A `fall` in ARMED before any `rise`-relative high phase is captured normally.
  - A `fall` in IDLE is discarded.
  - `cnt` never wraps, because it saturates at `TIMEOUT`.
- **Reset (asynchronous, active-low):** IDLE, `cnt` 0, synchronizer and history flops 0. All outputs 0: `period`, `high_time`, `valid`, `locked`, `timeout`, `in_tol`.
- `clear` produces the same state synchronously.

## Timing
- `sig_in` transition to `rise`/`fall` detection: 3 `Clock` cycles (two synchronizer stages plus the history compare).
- `rise` detection to `valid`, `period`, `high_time` and `locked` visible: 1 cycle (registered outputs).
- `in_tol` updates in the same cycle as `period`. It is registered and compares `cnt`+1, not `period`.
- `timeout` is asserted 1 cycle after the cycle in which `cnt` = `TIMEOUT`-1.
- Minimum measurable period is 2 cycles; minimum high or low phase is 1 cycle after synchronization.
- No backpressure. `valid` is a strobe and is never held.

## Configuration
- `PERIOD_METER_TOL_CHECK_EN` defined:
  - `in_tol` <= (`cnt`+1 >= `EXPECT_PERIOD`-`TOL`) and (`cnt`+1 <= `EXPECT_PERIOD`+`TOL`) on each publication.
  - The comparison is unsigned at `CNT_W`+1 bits so `EXPECT_PERIOD`-`TOL` cannot underflow.
  - `in_tol` is cleared on timeout.
- Not defined:
  - `in_tol` is tied to 0.
  - No comparators are synthesized.
  - `EXPECT_PERIOD` and `TOL` are ignored.

## Structure
- Shared package `slow_clock_pkg` holds:
  - the state enum `meter_state_t` {IDLE, ARMED, RUN};
  - the default `TIMEOUT` and `EXPECT_PERIOD` constants, so that the divider and the meter share one definition.
- One sub-module: `sync_edge_detect` (two-flop synchronizer plus history flop, producing `rise` and `fall`). It is reusable for KEY and SW inputs.

## Test plan
Unless a test says otherwise, parameters are `TIMEOUT`=100, `EXPECT_PERIOD`=20, `TOL`=2.
- **Reset values:** assert `reset` mid-count in RUN → all outputs 0 immediately; the first `rise` after release publishes nothing.
- **Steady square wave:** `sig_in` with period 20, high 10, running → from the second `rise` on, `valid` pulses every 20 cycles with `period`=20, `high_time`=10, `locked`=1, `in_tol`=1 (macro on).
- **Drift and tolerance:** period changes to 23 → `period`=23 and `in_tol`=0. Period changes to 18 → `in_tol`=1. Without the macro, `in_tol` stays 0 throughout.
- **Input loss:** hold `sig_in` low after lock → after 100 cycles, `timeout`=1 and `locked`=0, with `period` and `high_time` held. The next two rises clear `timeout` and publish.
- **Clear collision:** pulse `clear` in the same cycle as a detected `rise` → no `valid`, state IDLE, outputs 0.
- **Stuck high:** `sig_in` rises, stays high for 30 cycles, then falls and rises again at 40 → `period`=40, `high_time`=30.
